// File: rtl/spi_pkg.sv
// spi_pkg: frame-width encodings and the data mask shared by the SPI transmit and receive paths.
package spi_pkg;
   localparam logic [1:0] DF_8B  = 2'b00;
   localparam logic [1:0] DF_16B = 2'b01;
   localparam logic [1:0] DF_32B = 2'b10;

   function automatic logic [31:0] df_mask(input logic [1:0] df);
      return (df == DF_8B) ? 32'h0000_00ff : (df == DF_16B) ? 32'h0000_ffff : 32'hffff_ffff;
   endfunction
endpackage

// File: rtl/spi_tx_fifo_mem.sv
// spi_tx_fifo_mem: word storage with a synchronous write port and an asynchronous read port.
module spi_tx_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          sclk_tx,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge sclk_tx)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];
endmodule

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: show-ahead transmit FIFO feeding the SPI shifter; define SPI_TX_FIFO_UDR_EN to enable underrun detection.
module spi_tx_fifo
   import spi_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TXE_THR = 1
) (
   input  logic                     sclk_tx,
   input  logic                     spi_tx_rst,
   input  logic                     wr_en,
   input  logic [31:0]              wr_data,
   input  logic [1:0]               df,
   input  logic                     rxonly,
   input  logic                     flush,
   input  logic                     tx_start,
   input  logic                     ovr_clr,
   input  logic                     udr_clr,
   output logic [31:0]              spi_tx_data,
   output logic                     txe,
   output logic                     tx_full,
   output logic [$clog2(DEPTH):0]   tx_level,
   output logic                     ovr,
   output logic                     udr
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] lvl_d;
   logic [31:0]   head;
   logic          empty, pop, push, ovr_set, udr_set;

   assign empty   = (tx_level == '0);
   assign pop     = tx_start & ~rxonly & ~empty;
   assign push    = wr_en & (~tx_full | pop);
   assign ovr_set = wr_en & tx_full & ~pop;
   assign udr_set = tx_start & ~rxonly & empty;
   assign lvl_d   = flush ? '0 : tx_level + LW'(push) - LW'(pop);

   spi_tx_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .sclk_tx (sclk_tx),
      .we      (push & ~flush),
      .waddr   (wr_ptr),
      .wdata   (wr_data),
      .raddr   (rd_ptr),
      .rdata   (head)
   );

   assign spi_tx_data = empty ? '0 : head & df_mask(df);

   always_ff @(posedge sclk_tx) begin
      if (spi_tx_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_level <= '0;
         tx_full  <= 1'b0;
         txe      <= 1'b1;
         ovr      <= 1'b0;
      end else begin
         wr_ptr   <= flush ? '0 : wr_ptr + AW'(push);
         rd_ptr   <= flush ? '0 : rd_ptr + AW'(pop);
         tx_level <= lvl_d;
         tx_full  <= (lvl_d == LW'(DEPTH));
         txe      <= (lvl_d <= LW'(TXE_THR));
         ovr      <= ovr_set | (ovr & ~ovr_clr);
      end
   end

`ifdef SPI_TX_FIFO_UDR_EN
   always_ff @(posedge sclk_tx)
      udr <= spi_tx_rst ? 1'b0 : udr_set | (udr & ~udr_clr);
`else
   logic unused_udr;
   assign unused_udr = udr_clr | udr_set;
   assign udr        = 1'b0;
`endif
endmodule

// File: tb/tb_spi_tx_fifo.sv
// tb_spi_tx_fifo: directed vector table plus hand sequences for the SPI transmit FIFO.
module tb_spi_tx_fifo;
   import spi_pkg::*;

`ifdef SPI_TX_FIFO_UDR_EN
   localparam logic UDR_ON = 1'b1;
`else
   localparam logic UDR_ON = 1'b0;
`endif

   logic        sclk_tx = 0, spi_tx_rst = 1;
   logic        wr_en = 0, rxonly = 0, flush = 0, tx_start = 0, ovr_clr = 0, udr_clr = 0;
   logic [31:0] wr_data = 0;
   logic [1:0]  df = DF_8B;
   logic [31:0] spi_tx_data;
   logic        txe, tx_full, ovr, udr;
   logic [2:0]  tx_level;
   int          n_cmp = 0, n_bad = 0;

   always #5 sclk_tx = ~sclk_tx;

   spi_tx_fifo #(.DEPTH(4), .TXE_THR(1)) dut (
      .sclk_tx     (sclk_tx),
      .spi_tx_rst  (spi_tx_rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .df          (df),
      .rxonly      (rxonly),
      .flush       (flush),
      .tx_start    (tx_start),
      .ovr_clr     (ovr_clr),
      .udr_clr     (udr_clr),
      .spi_tx_data (spi_tx_data),
      .txe         (txe),
      .tx_full     (tx_full),
      .tx_level    (tx_level),
      .ovr         (ovr),
      .udr         (udr)
   );

   typedef struct {
      logic        wr;
      logic [31:0] wd;
      logic [1:0]  df;
      logic        st, rxo, fl, oc, uc;
      logic [2:0]  lvl;
      logic [31:0] data;
      logic        txe, full, ovr, udr;
   } vec_t;

   function automatic vec_t v(logic wr, logic [31:0] wd, logic [1:0] d, logic st, logic rxo, logic fl,
                              logic oc, logic uc, logic [2:0] lvl, logic [31:0] data,
                              logic e, logic f, logic o, logic u);
      v = '{wr, wd, d, st, rxo, fl, oc, uc, lvl, data, e, f, o, u};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic wr, logic [31:0] wd, logic st, logic rxo, logic fl);
      wr_en = wr; wr_data = wd; tx_start = st; rxonly = rxo; flush = fl;
      @(posedge sclk_tx); #1;
      wr_en = 0; tx_start = 0; rxonly = 0; flush = 0; ovr_clr = 0; udr_clr = 0;
   endtask

   vec_t vecs[$];

   initial begin
      // wr, data, df, start, rxonly, flush, ovr_clr, udr_clr -> level, data, txe, full, ovr, udr
      vecs.push_back(v(1, 32'h0000_00A5, DF_8B,  0,0,0,0,0, 1, 32'h0000_00A5, 1,0,0,0));
      vecs.push_back(v(1, 32'h0000_005A, DF_8B,  0,0,0,0,0, 2, 32'h0000_00A5, 0,0,0,0));
      vecs.push_back(v(1, 32'h0000_003C, DF_8B,  0,0,0,0,0, 3, 32'h0000_00A5, 0,0,0,0));
      vecs.push_back(v(1, 32'h1111_1177, DF_8B,  0,0,0,0,0, 4, 32'h0000_00A5, 0,1,0,0));
      vecs.push_back(v(1, 32'hDEAD_BEEF, DF_8B,  0,0,0,0,0, 4, 32'h0000_00A5, 0,1,1,0));
      vecs.push_back(v(0, 0,             DF_8B,  1,0,0,0,0, 3, 32'h0000_005A, 0,0,1,0));
      vecs.push_back(v(0, 0,             DF_8B,  1,0,0,1,0, 2, 32'h0000_003C, 0,0,0,0));
      vecs.push_back(v(0, 0,             DF_8B,  1,0,0,0,0, 1, 32'h0000_0077, 1,0,0,0));
      vecs.push_back(v(0, 0,             DF_8B,  1,0,0,0,0, 0, 32'h0000_0000, 1,0,0,0));
      vecs.push_back(v(0, 0,             DF_8B,  1,0,0,0,0, 0, 32'h0000_0000, 1,0,0,1));
      vecs.push_back(v(0, 0,             DF_8B,  1,0,0,0,1, 0, 32'h0000_0000, 1,0,0,1));
      vecs.push_back(v(0, 0,             DF_8B,  0,0,0,0,1, 0, 32'h0000_0000, 1,0,0,0));
      vecs.push_back(v(1, 32'h1234_5678, DF_16B, 0,0,0,0,0, 1, 32'h0000_5678, 1,0,0,0));
      vecs.push_back(v(0, 0,             DF_32B, 0,0,0,0,0, 1, 32'h1234_5678, 1,0,0,0));
      vecs.push_back(v(0, 0,             2'b11,  0,0,0,0,0, 1, 32'h1234_5678, 1,0,0,0));
      vecs.push_back(v(1, 32'h0000_0001, DF_32B, 0,0,0,0,0, 2, 32'h1234_5678, 0,0,0,0));
      vecs.push_back(v(1, 32'h0000_0002, DF_32B, 0,0,0,0,0, 3, 32'h1234_5678, 0,0,0,0));
      vecs.push_back(v(0, 0,             DF_32B, 1,1,0,0,0, 3, 32'h1234_5678, 0,0,0,0));
      vecs.push_back(v(1, 32'h0000_0003, DF_32B, 1,1,0,0,0, 4, 32'h1234_5678, 0,1,0,0));
      vecs.push_back(v(1, 32'h0000_0004, DF_32B, 1,0,0,0,0, 4, 32'h0000_0001, 0,1,0,0));
      vecs.push_back(v(0, 0,             DF_32B, 0,0,1,0,0, 0, 32'h0000_0000, 1,0,0,0));
      vecs.push_back(v(1, 32'h0000_0005, DF_32B, 0,0,1,0,0, 0, 32'h0000_0000, 1,0,0,0));
      vecs.push_back(v(0, 0,             DF_32B, 1,1,0,0,0, 0, 32'h0000_0000, 1,0,0,0));
      vecs.push_back(v(1, 32'h0000_0009, DF_32B, 1,0,0,0,0, 1, 32'h0000_0009, 1,0,0,1));
      vecs.push_back(v(0, 0,             DF_32B, 0,0,0,0,1, 1, 32'h0000_0009, 1,0,0,0));

      repeat (2) @(posedge sclk_tx);
      #1 spi_tx_rst = 0;
      chk("rst level", 32'(tx_level), 0);
      chk("rst data", spi_tx_data, 0);
      chk("rst txe", 32'(txe), 1);
      chk("rst full", 32'(tx_full), 0);
      chk("rst ovr", 32'(ovr), 0);
      chk("rst udr", 32'(udr), 0);

      foreach (vecs[i]) begin
         wr_en = vecs[i].wr; wr_data = vecs[i].wd; df = vecs[i].df; tx_start = vecs[i].st;
         rxonly = vecs[i].rxo; flush = vecs[i].fl; ovr_clr = vecs[i].oc; udr_clr = vecs[i].uc;
         @(posedge sclk_tx); #1;
         chk($sformatf("v%0d level", i), 32'(tx_level), 32'(vecs[i].lvl));
         chk($sformatf("v%0d data", i), spi_tx_data, vecs[i].data);
         chk($sformatf("v%0d txe", i), 32'(txe), 32'(vecs[i].txe));
         chk($sformatf("v%0d full", i), 32'(tx_full), 32'(vecs[i].full));
         chk($sformatf("v%0d ovr", i), 32'(ovr), 32'(vecs[i].ovr));
         chk($sformatf("v%0d udr", i), 32'(udr), 32'(vecs[i].udr & UDR_ON));
      end
      wr_en = 0; tx_start = 0; rxonly = 0; flush = 0; ovr_clr = 0; udr_clr = 0;

      // reset with words held discards them
      df = DF_32B;
      drive(1, 32'hAAAA_0001, 0, 0, 0);
      drive(1, 32'hAAAA_0002, 0, 0, 0);
      spi_tx_rst = 1;
      @(posedge sclk_tx); #1;
      spi_tx_rst = 0;
      chk("midrst level", 32'(tx_level), 0);
      chk("midrst data", spi_tx_data, 0);
      chk("midrst txe", 32'(txe), 1);
      chk("midrst udr", 32'(udr), 0);

      // full FIFO with simultaneous push/pop: new word comes out last
      drive(1, 32'h0000_0011, 0, 0, 0);
      drive(1, 32'h0000_0022, 0, 0, 0);
      drive(1, 32'h0000_0033, 0, 0, 0);
      drive(1, 32'h0000_0044, 0, 0, 0);
      chk("fill full", 32'(tx_full), 1);
      drive(1, 32'h0000_0055, 1, 0, 0);
      chk("pp level", 32'(tx_level), 4);
      chk("pp ovr", 32'(ovr), 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain%0d data", k), spi_tx_data, 32'h22 + 32'(k) * 32'h11);
         drive(0, 0, 1, 0, 0);
         repeat (5) @(posedge sclk_tx);
         #1;
      end
      chk("drain level", 32'(tx_level), 0);
      chk("drain data", spi_tx_data, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
